// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline.
// Decodes stall, flush, forwarding and PC-redirect controls from the EX-stage
// hazard/branch information. It also sequences the halt drain and keeps
// saturating stall/flush event counters.
module pipe_hazard_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 1,  // 1..7
   parameter int unsigned DRAIN_CYCLES = 4,  // 1..15
   parameter int unsigned CNT_W        = 16
) (
   input  logic              CLOCK,
   input  logic              RESET,
   input  logic              hazardArs,
   input  logic              hazardArt,
   input  logic              hazardBrs,
   input  logic              hazardBrt,
   input  logic              stallsigE,
   input  logic              BranchE,
   input  logic [31:0]       targetaddE,
   input  logic              haltD,
   output logic              stallF,
   output logic              stallD,
   output logic              stallE,
   output logic              ALUflush,
   output logic              flushD,
   output logic              forwardArs,
   output logic              forwardArt,
   output logic              forwardBrs,
   output logic              forwardBrt,
   output logic              forwardCrs,
   output logic              forwardCrt,
   output logic              pcRedirect,
   output logic [31:0]       pcTarget,
   output logic              haltDone,
   output logic [CNT_W-1:0]  stallCount,
   output logic [CNT_W-1:0]  flushCount,
   output logic [2:0]        stateOut
);

   typedef enum logic [2:0] {
      StRun      = 3'd0,
      StLoadWait = 3'd1,
      StFlush    = 3'd2,
      StDrain    = 3'd3,
      StHalted   = 3'd4
   } state_e;

   // The branch cycle itself is the first flush cycle, so FLUSH covers the rest.
   localparam logic [2:0] FlushInit = 3'(FLUSH_CYCLES - 1);
   localparam logic [3:0] DrainInit = 4'(DRAIN_CYCLES);

   state_e            state_q, state_d;
   logic [2:0]        flush_left_q, flush_left_d;
   logic [3:0]        drain_left_q, drain_left_d;
   logic              lat_brs_q, lat_brs_d;
   logic              lat_brt_q, lat_brt_d;
   logic [31:0]       pc_target_q, pc_target_d;
   logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
   logic              stall_inc, flush_inc, take_branch;

   // Next-state and control-output decode from current state and inputs.
   always_comb begin
      state_d      = state_q;
      flush_left_d = flush_left_q;
      drain_left_d = drain_left_q;
      lat_brs_d    = lat_brs_q;
      lat_brt_d    = lat_brt_q;
      pc_target_d  = pc_target_q;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;
      take_branch  = 1'b0;
      stallF       = 1'b0;
      stallD       = 1'b0;
      stallE       = 1'b0;
      ALUflush     = 1'b0;
      flushD       = 1'b0;
      forwardArs   = 1'b0;
      forwardArt   = 1'b0;
      forwardBrs   = 1'b0;
      forwardBrt   = 1'b0;
      forwardCrs   = 1'b0;
      forwardCrt   = 1'b0;
      pcRedirect   = 1'b0;
      pcTarget     = pc_target_q;
      haltDone     = 1'b0;

      unique case (state_q)
         StRun: begin
            forwardArs = hazardArs;
            forwardArt = hazardArt;
            if (BranchE) begin
               take_branch = 1'b1;
            end else if (stallsigE) begin
               stallF    = 1'b1;
               stallD    = 1'b1;
               stallE    = 1'b1;
               lat_brs_d = hazardBrs;
               lat_brt_d = hazardBrt;
               stall_inc = 1'b1;
               state_d   = StLoadWait;
            end else if (haltD) begin
               stallF       = 1'b1;
               drain_left_d = DrainInit;
               state_d      = StDrain;
            end
         end
         StLoadWait: begin
            forwardArs = hazardArs;
            forwardArt = hazardArt;
            forwardBrs = lat_brs_q;
            forwardBrt = lat_brt_q;
            forwardCrs = lat_brs_q;
            forwardCrt = lat_brt_q;
            lat_brs_d  = 1'b0;
            lat_brt_d  = 1'b0;
            state_d    = StRun;
            if (BranchE) begin
               take_branch = 1'b1;
            end
         end
         StFlush: begin
            // Wrong-path instructions: every request input is ignored here.
            ALUflush     = 1'b1;
            flushD       = 1'b1;
            flush_left_d = flush_left_q - 3'd1;
            if (flush_left_q <= 3'd1) begin
               flush_left_d = 3'd0;
               state_d      = StRun;
            end
         end
         StDrain: begin
            forwardArs = hazardArs;
            forwardArt = hazardArt;
            if (BranchE) begin
               // Halt sat on the wrong path; the redirect cancels it.
               take_branch = 1'b1;
            end else begin
               stallF       = 1'b1;
               stallD       = 1'b1;
               stallE       = stallsigE;
               drain_left_d = drain_left_q - 4'd1;
               if (drain_left_q <= 4'd1) begin
                  drain_left_d = 4'd0;
                  state_d      = StHalted;
               end
            end
         end
         StHalted: begin
            haltDone = 1'b1;
            stallF   = 1'b1;
            stallD   = 1'b1;
            stallE   = 1'b1;
         end
         default: begin
            state_d = StRun;
         end
      endcase

      if (take_branch) begin
         pcRedirect  = 1'b1;
         pcTarget    = targetaddE;
         pc_target_d = targetaddE;
         ALUflush    = 1'b1;
         flushD      = 1'b1;
         flush_inc   = 1'b1;
         if (FLUSH_CYCLES > 1) begin
            state_d      = StFlush;
            flush_left_d = FlushInit;
         end else begin
            state_d = StRun;
         end
      end
   end

   // State, latched hazard flags, redirect target and saturating counters.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q      <= StRun;
         flush_left_q <= 3'd0;
         drain_left_q <= 4'd0;
         lat_brs_q    <= 1'b0;
         lat_brt_q    <= 1'b0;
         pc_target_q  <= 32'd0;
         stall_cnt_q  <= '0;
         flush_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         flush_left_q <= flush_left_d;
         drain_left_q <= drain_left_d;
         lat_brs_q    <= lat_brs_d;
         lat_brt_q    <= lat_brt_d;
         pc_target_q  <= pc_target_d;
         if (stall_inc && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
         end
         if (flush_inc && (flush_cnt_q != '1)) begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
         end
      end
   end

   assign stallCount = stall_cnt_q;
   assign flushCount = flush_cnt_q;
   assign stateOut   = state_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage MIPS pipeline. It consumes the hazard flags, the load-use stall request and the branch/jump resolution produced by the execute stage. It drives stall, flush, forwarding-select, PC-redirect and halt-drain controls for the fetch, decode and execute stages. It also keeps saturating performance counters for stall and flush events.

Parameters:
FLUSH_CYCLES, 1, cycles ALUflush/flushD are held after a taken branch/jump (legal range 1..7)
DRAIN_CYCLES, 4, cycles allowed for in-flight instructions to retire after halt is decoded (legal range 1..15)
CNT_W, 16, width of the performance counters

Ports:
CLOCK  in  1  pipeline clock, rising edge
RESET  in  1  synchronous, active-high reset
hazardArs / hazardArt  in  1 each  EX-EX forwarding hazard flags (no stall)
hazardBrs / hazardBrt  in  1 each  load-use hazard flags
stallsigE  in  1  load-use stall request
BranchE  in  1  taken branch / j / jr / jal resolved in EX
targetaddE  in  32  word-address redirect target
haltD  in  1  decode holds the halt opcode (ALU control 5'b10010)
stallF / stallD / stallE  out  1 each  hold the PC, the IF/ID register, and the ALU stage (stallE inserts a bubble)
ALUflush / flushD  out  1 each  squash the EX and ID contents
forwardArs / forwardArt / forwardBrs / forwardBrt / forwardCrs / forwardCrt  out  1 each  forwarding selects into the ALU
pcRedirect  out  1  load targetaddE into the PC this cycle
pcTarget  out  32  redirect address
haltDone  out  1  pipeline drained; core halted
stallCount / flushCount  out  CNT_W each  saturating event counters
stateOut  out  3  current FSM state, for debug

Behaviour:
- States: RUN=0, LOADWAIT=1, FLUSH=2, DRAIN=3, HALTED=4. State, latches, counters and pcTarget are registered.
- Control outputs are a combinational decode of the current state plus current inputs. Any output not asserted below is 0.
- RESET (sampled at the clock edge) forces state RUN, both counters 0, latched B-flags 0, flush and drain counters 0, pcTarget 0. Reset in any state, including HALTED or mid-FLUSH, returns to RUN on the next cycle.
- Input priority in RUN: BranchE > stallsigE > haltD.
- RUN:
  - forwardArs/Art = hazardArs/Art pass-through.
  - If BranchE: pcRedirect=1, pcTarget=targetaddE (combinational in this cycle, also registered), ALUflush=1, flushD=1, flushCount+1. Next state is FLUSH with remaining=FLUSH_CYCLES-1, or RUN if FLUSH_CYCLES=1.
  - Else if stallsigE: stallF=stallD=stallE=1, latch hazardBrs/Brt, stallCount+1, next LOADWAIT.
  - Else if haltD: stallF=1, drain counter=DRAIN_CYCLES, next DRAIN.
- LOADWAIT (exactly 1 cycle):
  - forwardBrs/Brt and forwardCrs/Crt = latched flags.
  - forwardArs/Art pass-through; no stalls.
  - Latches clear; next RUN.
  - BranchE here is handled exactly as in RUN.
- FLUSH:
  - ALUflush=flushD=1; stallsigE, haltD and BranchE are ignored (wrong path).
  - Decrement remaining; return to RUN when it reaches 0.
- DRAIN:
  - stallF=stallD=1; forwardA* pass-through.
  - If BranchE: halt was wrong-path; perform the RUN branch action and go to FLUSH/RUN with halt cancelled.
  - Else decrement; on reaching 0 go to HALTED.
  - stallsigE in DRAIN: stallE=1 for that cycle; drain count still decrements.
- HALTED: haltDone=1, stallF=stallD=stallE=1; all other inputs ignored until RESET.
- Counters saturate at all-ones and never wrap.
- Simultaneous BranchE and stallsigE in RUN: the branch wins, no stall, stallCount unchanged.

Test Plan:
- Reset then idle: all control outputs 0, stateOut=0, counters 0. hazardArt=1 → forwardArt=1 in the same cycle.
- stallsigE=1, hazardBrs=1 for 1 cycle → stallF/D/E=1 that cycle. Next cycle forwardBrs=forwardCrs=1, stateOut=1. Cycle after that, RUN with stallCount=1.
- BranchE=1, targetaddE=0x40 with FLUSH_CYCLES=3 → pcRedirect=1, pcTarget=0x40, ALUflush/flushD high for 3 cycles, flushCount=1. A stallsigE pulse during FLUSH does not increment stallCount.
- BranchE and stallsigE asserted together → redirect only, stallF=0, stallCount=0.
- haltD=1 with DRAIN_CYCLES=4 → DRAIN for 4 cycles, then haltDone=1 and all stalls high. RESET then returns to RUN with haltDone=0.
- haltD, then BranchE=1 (target 0x10) in the second DRAIN cycle → redirect to 0x10, halt cancelled, haltDone never asserts.
